// File: rtl/pipelined_instr_decoder.sv
// Registered instruction decoder: slices raw instructions into fields, flags
// illegal opcodes and buffers decoded records in a DEPTH-entry output FIFO.
`timescale 1ns/1ps
module pipelined_instr_decoder #(
  parameter int unsigned IW      = 16,
  parameter int unsigned OPW     = 5,
  parameter int unsigned RW      = 3,
  parameter int unsigned DMW     = 4,
  parameter int unsigned IMW     = 6,
  parameter int unsigned SRW     = 3,
  parameter int unsigned NUM_OPS = 24,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  opcode,
  output logic            addressing_mode,
  output logic [RW-1:0]   rd,
  output logic [RW-1:0]   rs1,
  output logic [RW-1:0]   rs2,
  output logic [DMW-1:0]  data_mem,
  output logic [IMW-1:0]  instruction_mem,
  output logic [SRW-1:0]  s_r_amount,
  output logic            illegal,
  output logic [CNTW-1:0] decode_count
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned MODE_B = IW - OPW - 1;
  localparam int unsigned RD_HI  = MODE_B - 1;
  localparam int unsigned RS1_HI = RD_HI - RW;
  localparam int unsigned RS2_HI = RS1_HI - RW;

  // Reject field layouts that do not fit the instruction and non-power-of-two depths.
  if ((OPW + 1 + 3 * RW > IW) || (DMW > IW) || (IMW > IW) || (SRW > IW) ||
      (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
    $error("pipelined_instr_decoder: invalid parameter combination");
  end

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic           mode;
    logic [RW-1:0]  rd;
    logic [RW-1:0]  rs1;
    logic [RW-1:0]  rs2;
    logic [DMW-1:0] data_mem;
    logic [IMW-1:0] instruction_mem;
    logic [SRW-1:0] s_r_amount;
    logic           illegal;
  } rec_t;

  rec_t          dec;
  rec_t          head;
  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Combinational field extraction from the incoming instruction.
  always_comb begin
    dec                 = '0;
    dec.opcode          = in_instr[IW-1 -: OPW];
    dec.mode            = in_instr[MODE_B];
    dec.rd              = in_instr[RD_HI -: RW];
    dec.rs1             = in_instr[RS1_HI -: RW];
    dec.rs2             = in_instr[RS2_HI -: RW];
    dec.data_mem        = in_instr[DMW-1:0];
    dec.instruction_mem = in_instr[IMW-1:0];
    dec.s_r_amount      = in_instr[SRW-1:0];
    dec.illegal         = 32'(dec.opcode) >= NUM_OPS;
  end

  // Extra pointer bit distinguishes full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      decode_count <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) decode_count <= decode_count + CNTW'(1);
    end
  end

  // Storage needs no reset: every read is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= dec;
  end

  assign head            = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign opcode          = head.opcode;
  assign addressing_mode = head.mode;
  assign rd              = head.rd;
  assign rs1             = head.rs1;
  assign rs2             = head.rs2;
  assign data_mem        = head.data_mem;
  assign instruction_mem = head.instruction_mem;
  assign s_r_amount      = head.s_r_amount;
  assign illegal         = head.illegal;

endmodule
